// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, state encoding and PC arithmetic for the fetch stage
package pipe_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    SVC  = 2'd2
  } irq_state_t;

  // Sequential successor: the supervisor bit is carried through untouched and
  // the carry out of bit 30 is discarded.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

  // j/jal target: region bits from the ID-stage PC_plus_4, word index from the instruction.
  function automatic logic [31:0] jump_pc(input logic [3:0] region, input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_stage_if.sv
// rtl/if_pc_stage_if.sv - fetch-stage bus between ROM, ID/EX hazard logic and the IF/ID register
interface if_pc_stage_if;

  logic [31:0] Instruction;
  logic        stall;
  logic        id_jump;
  logic        id_jr;
  logic [25:0] id_jump_target;
  logic [31:0] id_jr_target;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        id_illop;
  logic [31:0] id_pc_plus_4;
  logic        irq;

  logic [31:0] PC;
  logic [31:0] PC_plus_4;
  logic [31:0] IF_Instruction;
  logic        flush_ifid;
  logic        flush_idex;
  logic        hold_ifid;
  logic [31:0] EPC;
  logic        irq_taken;

  // Pipeline side: drives ROM data and hazard/redirect requests, consumes fetch results.
  modport master (
    output Instruction, stall, id_jump, id_jr, id_jump_target, id_jr_target,
           ex_branch_taken, ex_branch_target, id_illop, id_pc_plus_4, irq,
    input  PC, PC_plus_4, IF_Instruction, flush_ifid, flush_idex, hold_ifid,
           EPC, irq_taken
  );

  // Fetch stage side.
  modport slave (
    input  Instruction, stall, id_jump, id_jr, id_jump_target, id_jr_target,
           ex_branch_taken, ex_branch_target, id_illop, id_pc_plus_4, irq,
    output PC, PC_plus_4, IF_Instruction, flush_ifid, flush_idex, hold_ifid,
           EPC, irq_taken
  );

endinterface

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - next-PC priority selection, redirect target arithmetic and pipeline controls
module pc_next_mux
  import pipe_pkg::*;
#(
  parameter logic [31:0] IRQ_VEC = pipe_pkg::IRQ_VEC,
  parameter logic [31:0] EXC_VEC = pipe_pkg::EXC_VEC
) (
  input  logic [31:0] pc,
  input  logic [3:0]  id_region,
  input  logic        stall,
  input  logic        id_jump,
  input  logic        id_jr,
  input  logic [25:0] id_jump_target,
  input  logic [31:0] id_jr_target,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        id_illop,
  input  logic        irq_accept,
  output logic [31:0] pc_plus_4,
  output logic [31:0] next_pc,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        hold_ifid,
  output logic        epc_load
);

  logic [31:0] jump_target;

  assign pc_plus_4   = seq_pc(pc);
  assign jump_target = jump_pc(id_region, id_jump_target);

  // Priority chain: exception, interrupt, EX branch, ID jump/jr, stall, sequential.
  // Any redirect wins over a stall, so hold_ifid is only raised on the stall leg.
  always_comb begin
    next_pc    = pc_plus_4;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    hold_ifid  = 1'b0;
    epc_load   = 1'b0;
    if (id_illop) begin
      next_pc    = EXC_VEC;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      epc_load   = 1'b1;
    end else if (irq_accept) begin
      next_pc    = IRQ_VEC;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      epc_load   = 1'b1;
    end else if (ex_branch_taken) begin
      next_pc    = ex_branch_target;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (id_jr) begin
      // jr lands exactly on rs, so bit 31 of rs decides whether supervisor mode is left.
      next_pc    = id_jr_target;
      flush_ifid = 1'b1;
    end else if (id_jump) begin
      next_pc    = jump_target;
      flush_ifid = 1'b1;
    end else if (stall) begin
      next_pc    = pc;
      hold_ifid  = 1'b1;
      flush_idex = 1'b1;
    end
  end

endmodule

// File: rtl/if_pc_stage.sv
// rtl/if_pc_stage.sv - MIPS instruction-fetch stage: PC/EPC registers and interrupt entry FSM
module if_pc_stage #(
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
  parameter logic [31:0] IRQ_VEC  = pipe_pkg::IRQ_VEC,
  parameter logic [31:0] EXC_VEC  = pipe_pkg::EXC_VEC
) (
  input  logic         clk,
  input  logic         reset,
  if_pc_stage_if.slave bus
);

  import pipe_pkg::*;

  irq_state_t  state;
  irq_state_t  state_next;
  logic [31:0] pc_q;
  logic [31:0] epc_q;
  logic [31:0] pc_plus_4;
  logic [31:0] next_pc;
  logic        mux_flush_ifid;
  logic        mux_flush_idex;
  logic        mux_hold_ifid;
  logic        epc_load;
  logic        irq_accept;

  // A pending interrupt is only taken in a clean cycle so EPC never lands in a squashed shadow.
  assign irq_accept = (state == PEND) && bus.irq && !bus.stall && !bus.ex_branch_taken &&
                      !bus.id_jump && !bus.id_jr && !bus.id_illop;

  pc_next_mux #(
    .IRQ_VEC (IRQ_VEC),
    .EXC_VEC (EXC_VEC)
  ) u_pc_next_mux (
    .pc               (pc_q),
    .id_region        (bus.id_pc_plus_4[31:28]),
    .stall            (bus.stall),
    .id_jump          (bus.id_jump),
    .id_jr            (bus.id_jr),
    .id_jump_target   (bus.id_jump_target),
    .id_jr_target     (bus.id_jr_target),
    .ex_branch_taken  (bus.ex_branch_taken),
    .ex_branch_target (bus.ex_branch_target),
    .id_illop         (bus.id_illop),
    .irq_accept       (irq_accept),
    .pc_plus_4        (pc_plus_4),
    .next_pc          (next_pc),
    .flush_ifid       (mux_flush_ifid),
    .flush_idex       (mux_flush_idex),
    .hold_ifid        (mux_hold_ifid),
    .epc_load         (epc_load)
  );

  // Interrupt FSM state register; reset aborts any pending or in-service interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Interrupt FSM transitions: masked in supervisor mode, one entry per return to user mode.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (bus.irq && !pc_q[31]) begin
          state_next = PEND;
        end
      end
      PEND: begin
        if (bus.id_illop || irq_accept) begin
          state_next = SVC;
        end else if (!bus.irq) begin
          state_next = RUN;
        end
      end
      SVC: begin
        if (!pc_q[31]) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // PC advances every cycle to the selected next address; EPC captures the ID return address on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      epc_q <= '0;
    end else begin
      pc_q <= next_pc;
      if (epc_load) begin
        epc_q <= bus.id_pc_plus_4;
      end
    end
  end

  assign bus.PC             = pc_q;
  assign bus.PC_plus_4      = pc_plus_4;
  assign bus.EPC            = epc_q;
  assign bus.flush_ifid     = reset & mux_flush_ifid;
  assign bus.flush_idex     = reset & mux_flush_idex;
  assign bus.hold_ifid      = reset & mux_hold_ifid;
  assign bus.irq_taken      = reset & irq_accept;
  assign bus.IF_Instruction = bus.flush_ifid ? NOP : bus.Instruction;

endmodule

// File: doc/if_pc_stage.md
Name: if_pc_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the IF/ID pipeline register and feeds it PC_plus_4 and Instruction.
- Owns the PC register and next-PC selection: sequential, ID jump/jr, EX branch, interrupt, exception.
- Generates the stall and flush controls for the IF/ID and ID/EX registers, and captures the EPC.
- Instruction ROM is external and combinational: it is addressed by PC and returns Instruction in the same cycle.

Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset (supervisor bit set).
- IRQ_VEC, 32'h8000_0004, interrupt entry address.
- EXC_VEC, 32'h8000_0008, illegal-op/undefined-instruction entry address.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- Instruction  in  32  ROM data at address PC.
- stall  in  1  load-use stall request from the hazard unit.
- id_jump  in  1  ID stage decoded j/jal.
- id_jr  in  1  ID stage decoded jr/jalr.
- id_jump_target  in  26  ID instruction[25:0].
- id_jr_target  in  32  forwarded rs value in ID.
- ex_branch_taken  in  1  EX branch resolved taken.
- ex_branch_target  in  32  EX PC_plus_4 + (imm<<2).
- id_illop  in  1  ID detected an undefined opcode.
- id_pc_plus_4  in  32  PC_plus_4 held in IF/ID, used for EPC capture.
- irq  in  1  level interrupt request from the timer peripheral.
- PC  out  32  current fetch address to the ROM.
- PC_plus_4  out  32  to IF/ID.
- IF_Instruction  out  32  to IF/ID; forced to 0 (nop) when flush_ifid=1.
- flush_ifid  out  1  load a bubble into IF/ID.
- flush_idex  out  1  load a bubble into ID/EX.
- hold_ifid  out  1  IF/ID keeps its current contents.
- EPC  out  32  exception return address (register).
- irq_taken  out  1  one-cycle pulse when the interrupt vector is loaded.

Behaviour:
- Reset (asynchronous, active-low) sets:
  - PC=RESET_PC, EPC=0.
  - state=RUN, irq_pend=0.
  - All pulse outputs 0.
- PC_plus_4 = {PC[31], PC[30:0]+4}. Bit 31 (supervisor) is never changed by the increment; carry out of bit 30 is dropped.
- Jump target = {PC_plus_4_of_ID[31:28], id_jump_target, 2'b00}, with PC_plus_4_of_ID taken from id_pc_plus_4.
- jr target = id_jr_target exactly.
- The supervisor bit is cleared by jr only when id_jr_target[31]=0.
- Next-PC priority, evaluated every cycle with the highest first:
  1. id_illop: PC<=EXC_VEC, EPC<=id_pc_plus_4, flush_ifid=1, flush_idex=1.
  2. Interrupt accepted (see FSM): PC<=IRQ_VEC, EPC<=id_pc_plus_4, flush_ifid=1, flush_idex=1, irq_taken=1.
  3. ex_branch_taken: PC<=ex_branch_target, flush_ifid=1, flush_idex=1.
  4. id_jump or id_jr: PC<=target, flush_ifid=1, flush_idex=0.
  5. stall: PC holds, hold_ifid=1, flush_idex=1.
  6. Otherwise: PC<=PC_plus_4.
- A redirect (items 1-4) overrides stall. hold_ifid=0 whenever any redirect is active.
- Latency:
  - Redirect asserted in cycle N: the new PC is fetched in cycle N+1.
  - IF/ID captures the redirected instruction at the end of N+1.
- Interrupt FSM (state register):
  - RUN: on irq=1 with PC[31]=0, go to PEND. irq with PC[31]=1 is ignored (masked in supervisor mode).
  - PEND: accept (item 2) in the first cycle where stall=0, ex_branch_taken=0, id_jump=0, id_jr=0 and id_illop=0. On accept, go to SVC.
    - Deferral ensures EPC never points into a squashed branch/jump shadow.
    - irq dropping while in PEND returns to RUN without accepting.
  - SVC: wait until PC[31] returns to 0 (return from handler via jr), then go to RUN.
    - irq must be re-observed in RUN before a new entry; no back-to-back entry.
- id_illop while in PEND: exception wins, state goes to SVC, irq_taken stays 0.
- Reset asserted mid-operation aborts PEND/SVC immediately; EPC is cleared.

Decomposition:
- Shared package pipe_pkg:
  - RESET_PC, IRQ_VEC, EXC_VEC.
  - NOP=32'h0.
  - FSM state encoding RUN=2'd0, PEND=2'd1, SVC=2'd2.
- One sub-module: pc_next_mux. It is combinational and implements priority selection plus target arithmetic.
- The FSM, PC and EPC registers stay in if_pc_stage.

Test Plan:
- Reset release, no events -> PC goes 8000_0000, 8000_0004, 8000_0008; PC_plus_4 = PC+4 each cycle; all flushes 0.
- PC=0000_0010, stall=1 for 2 cycles -> PC stays 0000_0010, hold_ifid=1 and flush_idex=1 both cycles; next cycle PC=0000_0014.
- stall=1 and ex_branch_taken=1 with target 0000_0100 in the same cycle -> next PC=0000_0100, flush_ifid=1, flush_idex=1, hold_ifid=0.
- id_jump with id_pc_plus_4=0040_0008 and id_jump_target=26'h10 -> PC=0000_0040, flush_ifid=1, flush_idex=0.
- irq=1 at PC=0000_0020 during stall -> deferred until stall=0; then PC=8000_0004, irq_taken=1 for one cycle, EPC=id_pc_plus_4; irq held high while PC[31]=1 -> no second entry.
- id_illop while in PEND -> PC=8000_0008, irq_taken=0, state SVC. Reset pulsed low in SVC -> PC=8000_0000, EPC=0 asynchronously.
